// File: rtl/soc_pkg.sv
// Shared constants and types for mini_soc: peripheral base address, register map,
// STATUS bit positions and the FSM state encodings.
package soc_pkg;

    localparam logic [15:0] PERIPH_BASE = 16'h8300;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_PAR    = 2'd2;
    localparam logic [1:0] REG_I2C    = 2'd3;

    localparam int STAT_TX_BUSY = 0;
    localparam int STAT_RX_PEND = 1;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_RD_DATA,
        SEQ_WAIT_TX,
        SEQ_WR_TX,
        SEQ_WR_PAR,
        SEQ_CLR
    } seq_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // Word address of a register inside the peripheral window.
    function automatic logic [15:0] reg_addr(input logic [1:0] idx);
        return PERIPH_BASE | {13'b0, idx, 1'b0};
    endfunction

endpackage

// File: rtl/soc_periph.sv
// MMIO peripheral block: bus decoder, UART 8N1 TX/RX, parallel I/O and register 3.
// Register 3 becomes an I2C bit-bang port when SOC_I2C_EN is defined.
module soc_periph
    import soc_pkg::*;
#(
    parameter int BIT_CYCLES = 868
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_addr,
    input  logic [15:0] i_wdata,
    input  logic        i_sel,
    input  logic        i_we,
    input  logic        i_re,
    output logic [15:0] o_rdata,
    input  logic [3:0]  i_par_i,
    output logic [3:0]  o_par_o,
    input  logic        i_uart_rx,
    output logic        o_uart_tx,
    output logic        o_irq_req,
    inout  wire         io_i2c_sda,
    inout  wire         io_i2c_scl
);

    localparam int CW = $clog2(BIT_CYCLES);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CYCLES / 2 - 1);

    logic [1:0] idx;
    logic       hit, wr_en, wr_data, wr_status, wr_par;
    logic [15:0] i2c_rdata;
    logic       unused_bits;

    assign idx       = i_addr[2:1];
    assign hit       = i_sel && (i_addr[15:3] == PERIPH_BASE[15:3]);
    assign wr_en     = hit && i_we;
    assign wr_data   = wr_en && (idx == REG_DATA);
    assign wr_status = wr_en && (idx == REG_STATUS);
    assign wr_par    = wr_en && (idx == REG_PAR);
    assign unused_bits = ^{i_re, i_addr[0], i_wdata[15:8]};

    // UART TX: the shift register idles at all ones, so its LSB is the line itself.
    logic          tx_busy_reg;
    logic [9:0]    tx_shift_reg;
    logic [CW-1:0] tx_cnt_reg;
    logic [3:0]    tx_bit_reg;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            tx_busy_reg  <= 1'b0;
            tx_shift_reg <= '1;
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
        end else if (!tx_busy_reg) begin
            if (wr_data) begin
                tx_shift_reg <= {1'b1, i_wdata[7:0], 1'b0};
                tx_busy_reg  <= 1'b1;
                tx_cnt_reg   <= '0;
                tx_bit_reg   <= '0;
            end
        end else if (tx_cnt_reg == BIT_LAST) begin
            tx_cnt_reg   <= '0;
            tx_shift_reg <= {1'b1, tx_shift_reg[9:1]};
            if (tx_bit_reg == 4'd9)
                tx_busy_reg <= 1'b0;
            else
                tx_bit_reg <= tx_bit_reg + 4'd1;
        end else begin
            tx_cnt_reg <= tx_cnt_reg + 1'b1;
        end
    end

    assign o_uart_tx = tx_shift_reg[0];

    // UART RX: synchronized line, falling-edge arm, half-bit start re-check.
    logic          rx_meta_reg, rx_sync_reg, rx_prev_reg;
    rx_state_t     rx_state_reg, rx_state_next;
    logic [CW-1:0] rx_cnt_reg, rx_cnt_next;
    logic [2:0]    rx_bit_reg, rx_bit_next;
    logic [7:0]    rx_shift_reg, rx_shift_next;
    logic [7:0]    rx_data_reg;
    logic          rx_pending_reg;
    logic          rx_done;

    always_comb begin
        rx_state_next = rx_state_reg;
        rx_cnt_next   = rx_cnt_reg;
        rx_bit_next   = rx_bit_reg;
        rx_shift_next = rx_shift_reg;
        rx_done       = 1'b0;
        case (rx_state_reg)
            RX_IDLE: begin
                if (rx_prev_reg && !rx_sync_reg) begin
                    rx_state_next = RX_START;
                    rx_cnt_next   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt_reg == HALF_LAST) begin
                    rx_cnt_next   = '0;
                    rx_bit_next   = '0;
                    rx_state_next = rx_sync_reg ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_next = rx_cnt_reg + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_reg == BIT_LAST) begin
                    rx_cnt_next   = '0;
                    rx_shift_next = {rx_sync_reg, rx_shift_reg[7:1]};
                    if (rx_bit_reg == 3'd7)
                        rx_state_next = RX_STOP;
                    else
                        rx_bit_next = rx_bit_reg + 3'd1;
                end else begin
                    rx_cnt_next = rx_cnt_reg + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_reg == BIT_LAST) begin
                    rx_cnt_next   = '0;
                    rx_state_next = RX_IDLE;
                    rx_done       = rx_sync_reg;
                end else begin
                    rx_cnt_next = rx_cnt_reg + 1'b1;
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            rx_meta_reg    <= 1'b1;
            rx_sync_reg    <= 1'b1;
            rx_prev_reg    <= 1'b1;
            rx_state_reg   <= RX_IDLE;
            rx_cnt_reg     <= '0;
            rx_bit_reg     <= '0;
            rx_shift_reg   <= '0;
            rx_data_reg    <= '0;
            rx_pending_reg <= 1'b0;
        end else begin
            rx_meta_reg  <= i_uart_rx;
            rx_sync_reg  <= rx_meta_reg;
            rx_prev_reg  <= rx_sync_reg;
            rx_state_reg <= rx_state_next;
            rx_cnt_reg   <= rx_cnt_next;
            rx_bit_reg   <= rx_bit_next;
            rx_shift_reg <= rx_shift_next;
            // A completing byte beats a simultaneous clear.
            if (rx_done) begin
                rx_data_reg    <= rx_shift_reg;
                rx_pending_reg <= 1'b1;
            end else if (wr_status && i_wdata[STAT_RX_PEND]) begin
                rx_pending_reg <= 1'b0;
            end
        end
    end

    assign o_irq_req = rx_pending_reg;

    logic [3:0] par_meta_reg, par_sync_reg, par_out_reg;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            par_meta_reg <= '0;
            par_sync_reg <= '0;
            par_out_reg  <= '0;
        end else begin
            par_meta_reg <= i_par_i;
            par_sync_reg <= par_meta_reg;
            if (wr_par)
                par_out_reg <= i_wdata[3:0];
        end
    end

    assign o_par_o = par_out_reg;

`ifdef SOC_I2C_EN
    logic       wr_i2c;
    logic [1:0] i2c_out_reg, i2c_meta_reg, i2c_sync_reg;

    assign wr_i2c = wr_en && (idx == REG_I2C);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            i2c_out_reg  <= 2'b11;
            i2c_meta_reg <= 2'b11;
            i2c_sync_reg <= 2'b11;
        end else begin
            i2c_meta_reg <= {io_i2c_scl, io_i2c_sda};
            i2c_sync_reg <= i2c_meta_reg;
            if (wr_i2c)
                i2c_out_reg <= i_wdata[1:0];
        end
    end

    // Open-drain: a 1 releases the line, a 0 pulls it low.
    assign io_i2c_sda = i2c_out_reg[0] ? 1'bz : 1'b0;
    assign io_i2c_scl = i2c_out_reg[1] ? 1'bz : 1'b0;
    assign i2c_rdata  = {12'b0, i2c_out_reg, i2c_sync_reg};
`else
    assign io_i2c_sda = 1'bz;
    assign io_i2c_scl = 1'bz;
    assign i2c_rdata  = '0;
`endif

    always_comb begin
        o_rdata = '0;
        if (hit) begin
            case (idx)
                REG_DATA:   o_rdata = {8'b0, rx_data_reg};
                REG_STATUS: begin
                    o_rdata[STAT_TX_BUSY] = tx_busy_reg;
                    o_rdata[STAT_RX_PEND] = rx_pending_reg;
                end
                REG_PAR:    o_rdata = {12'b0, par_sync_reg};
                default:    o_rdata = i2c_rdata;
            endcase
        end
    end

endmodule

// File: rtl/mini_soc.sv
// mini_soc FPGA top: peripheral block plus a hardwired sequencer that echoes each
// received UART byte and drives its low nibble onto o_par_o. Optional macro: SOC_I2C_EN.
module mini_soc
    import soc_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_par_i,
    output logic [3:0] o_par_o,
    input  logic       i_uart_rx,
    output logic       o_uart_tx,
    inout  wire        io_i2c_sda,
    inout  wire        io_i2c_scl
);

    localparam int BIT_CYCLES = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;

    logic [15:0] bus_addr, bus_wdata, bus_rdata;
    logic        bus_sel, bus_we, bus_re;
    logic        irq_req;
    logic        unused_rdata;

    seq_state_t state_reg, state_next;
    logic [7:0] byte_reg, byte_next;

    assign unused_rdata = ^bus_rdata[15:8];

    soc_periph #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_periph (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_addr     (bus_addr),
        .i_wdata    (bus_wdata),
        .i_sel      (bus_sel),
        .i_we       (bus_we),
        .i_re       (bus_re),
        .o_rdata    (bus_rdata),
        .i_par_i    (i_par_i),
        .o_par_o    (o_par_o),
        .i_uart_rx  (i_uart_rx),
        .o_uart_tx  (o_uart_tx),
        .o_irq_req  (irq_req),
        .io_i2c_sda (io_i2c_sda),
        .io_i2c_scl (io_i2c_scl)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_reg <= SEQ_IDLE;
            byte_reg  <= '0;
        end else begin
            state_reg <= state_next;
            byte_reg  <= byte_next;
        end
    end

    // One bus access per state; the access completes on the edge that leaves it.
    always_comb begin
        state_next = state_reg;
        byte_next  = byte_reg;
        bus_addr   = '0;
        bus_wdata  = '0;
        bus_sel    = 1'b0;
        bus_we     = 1'b0;
        bus_re     = 1'b0;
        case (state_reg)
            SEQ_IDLE: begin
                if (irq_req)
                    state_next = SEQ_RD_DATA;
            end
            SEQ_RD_DATA: begin
                bus_sel    = 1'b1;
                bus_re     = 1'b1;
                bus_addr   = reg_addr(REG_DATA);
                byte_next  = bus_rdata[7:0];
                state_next = SEQ_WAIT_TX;
            end
            SEQ_WAIT_TX: begin
                bus_sel  = 1'b1;
                bus_re   = 1'b1;
                bus_addr = reg_addr(REG_STATUS);
                if (!bus_rdata[STAT_TX_BUSY])
                    state_next = SEQ_WR_TX;
            end
            SEQ_WR_TX: begin
                bus_sel    = 1'b1;
                bus_we     = 1'b1;
                bus_addr   = reg_addr(REG_DATA);
                bus_wdata  = {8'b0, byte_reg};
                state_next = SEQ_WR_PAR;
            end
            SEQ_WR_PAR: begin
                bus_sel    = 1'b1;
                bus_we     = 1'b1;
                bus_addr   = reg_addr(REG_PAR);
                bus_wdata  = {12'b0, byte_reg[3:0]};
                state_next = SEQ_CLR;
            end
            SEQ_CLR: begin
                bus_sel    = 1'b1;
                bus_we     = 1'b1;
                bus_addr   = reg_addr(REG_STATUS);
                bus_wdata  = 16'(1 << STAT_RX_PEND);
                state_next = SEQ_IDLE;
            end
            default: state_next = SEQ_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mini_soc.sv
// Directed bench for mini_soc at 2 Mbaud on a 100 MHz clock (50 clocks per bit):
// reset state, UART receive/echo/parallel-out, glitch and bad-stop rejection, mid-frame reset.
module tb_mini_soc;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [3:0] par_i = 4'h0;
    wire  [3:0] par_o;
    wire        tx;
    wire        sda;
    wire        scl;

    pullup (sda);
    pullup (scl);

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mini_soc #(
        .CLK_FREQ (100_000_000),
        .BAUD_RATE(2_000_000)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst_n),
        .i_par_i    (par_i),
        .o_par_o    (par_o),
        .i_uart_rx  (rx),
        .o_uart_tx  (tx),
        .io_i2c_sda (sda),
        .io_i2c_scl (scl)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
            $display("check %s: observed %h expected %h ok", tag, obs, exp);
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Start + 8 data bits; a good stop bit is left as the idle-high line.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        wait_clks(50);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_clks(50);
        end
        rx = stop_bit;
        if (!stop_bit) begin
            wait_clks(50);
            rx = 1'b1;
        end
    endtask

    // Waits (bounded) for the echo frame, then samples each bit at its middle.
    task automatic recv_byte(output logic [7:0] b, output logic found, output logic start_b,
                             output logic stop_b, output logic seen_pend, output logic busy0);
        found = 1'b0;
        seen_pend = 1'b0;
        b = 8'h00;
        start_b = 1'b1;
        stop_b = 1'b0;
        busy0 = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (dut.u_periph.rx_pending_reg === 1'b1) seen_pend = 1'b1;
            if (tx === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        busy0 = dut.u_periph.tx_busy_reg;
        if (found) begin
            wait_clks(25);
            start_b = tx;
            for (int i = 0; i < 8; i++) begin
                wait_clks(50);
                b[i] = tx;
            end
            wait_clks(50);
            stop_b = tx;
        end
    endtask

    task automatic echo_case(input logic [7:0] val);
        logic [7:0] got;
        logic found, start_b, stop_b, seen_pend, busy0;
        send_byte(val, 1'b1);
        recv_byte(got, found, start_b, stop_b, seen_pend, busy0);
        check($sformatf("echo_found_%h", val), 16'(found), 16'd1);
        check($sformatf("pend_pulse_%h", val), 16'(seen_pend), 16'd1);
        check($sformatf("busy_at_start_%h", val), 16'(busy0), 16'd1);
        check($sformatf("start_bit_%h", val), 16'(start_b), 16'd0);
        check($sformatf("echo_byte_%h", val), 16'(got), 16'(val));
        check($sformatf("stop_bit_%h", val), 16'(stop_b), 16'd1);
        wait_clks(20);
        check($sformatf("busy_late_stop_%h", val), 16'(dut.u_periph.tx_busy_reg), 16'd1);
        wait_clks(10);
        check($sformatf("busy_after_frame_%h", val), 16'(dut.u_periph.tx_busy_reg), 16'd0);
        check($sformatf("par_o_%h", val), 16'(par_o), 16'(val[3:0]));
        check($sformatf("pend_cleared_%h", val), 16'(dut.u_periph.rx_pending_reg), 16'd0);
    endtask

    initial begin
        int tx_lows;
        int pend_highs;
        logic found;

        wait_clks(5);
        check("reset_par_o", 16'(par_o), 16'h0);
        check("reset_tx", 16'(tx), 16'd1);
        check("reset_sda_released", 16'(sda !== 1'b0), 16'd1);
        check("reset_scl_released", 16'(scl !== 1'b0), 16'd1);
        check("reset_tx_busy", 16'(dut.u_periph.tx_busy_reg), 16'd0);
        check("reset_rx_pending", 16'(dut.u_periph.rx_pending_reg), 16'd0);
        check("reset_rx_data", 16'(dut.u_periph.rx_data_reg), 16'h0);

        rst_n = 1'b1;
        wait_clks(3);
        check("idle_tx", 16'(tx), 16'd1);

        echo_case(8'hA7);
        echo_case(8'h3C);

        // Low pulse shorter than half a bit must not start a byte.
        rx = 1'b0;
        wait_clks(10);
        rx = 1'b1;
        tx_lows = 0;
        pend_highs = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) tx_lows++;
            if (dut.u_periph.rx_pending_reg !== 1'b0) pend_highs++;
        end
        check("glitch_no_pending", 16'(pend_highs), 16'd0);
        check("glitch_no_echo", 16'(tx_lows), 16'd0);
        check("glitch_par_kept", 16'(par_o), 16'hC);

        // Frame with a low stop bit is discarded.
        send_byte(8'h55, 1'b0);
        tx_lows = 0;
        pend_highs = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) tx_lows++;
            if (dut.u_periph.rx_pending_reg !== 1'b0) pend_highs++;
        end
        check("badstop_no_pending", 16'(pend_highs), 16'd0);
        check("badstop_no_echo", 16'(tx_lows), 16'd0);
        check("badstop_par_kept", 16'(par_o), 16'hC);
        check("badstop_rx_data_kept", 16'(dut.u_periph.rx_data_reg), 16'h3C);

        // Reset during an echo frame returns the line high at once.
        send_byte(8'h81, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        check("midreset_frame_started", 16'(found), 16'd1);
        wait_clks(100);
        check("midreset_tx_low_before", 16'(tx), 16'd0);
        rst_n = 1'b0;
        wait_clks(1);
        check("midreset_tx_high", 16'(tx), 16'd1);
        check("midreset_busy_clear", 16'(dut.u_periph.tx_busy_reg), 16'd0);
        check("midreset_par_clear", 16'(par_o), 16'h0);
        rst_n = 1'b1;
        wait_clks(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
